mem_wb_stage: RTL

//  M->W pipeline register plus write-back datapath of the 5-stage MIPS core.

---
 rtl/mem_wb_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: M->W pipeline register and write-back datapath.
// It latches the memory-stage results, then extracts and extends load
// bytes and halfwords. It selects the write-back source, drives the GRF
// write port, and counts the GPR writes that commit.
// Ports:
//   clk, reset (async, active-low), stall, flush (flush beats stall)
//   M_PC/M_we/M_WA/M_ALUOut/M_DMRD/M_LdType/M_WDSel : memory-stage inputs
//   W_PC/W_we/W_WA : registered write-back controls
//   W_WD           : write data, combinational from the W registers
//   W_retired      : count of committed GPR writes
module mem_wb_stage #(
  parameter logic [31:0]  PC_RESET = 32'h0000_3000,
  parameter int unsigned  CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      M_PC,
  input  logic             M_we,
  input  logic [4:0]       M_WA,
  input  logic [31:0]      M_ALUOut,
  input  logic [31:0]      M_DMRD,
  input  logic [2:0]       M_LdType,
  input  logic [1:0]       M_WDSel,
  output logic [31:0]      W_PC,
  output logic             W_we,
  output logic [4:0]       W_WA,
  output logic [31:0]      W_WD,
  output logic [CNT_W-1:0] W_retired
);

  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC8  = 2'd2;

  logic [31:0]      pc_q,   pc_d;
  logic             we_q,   we_d;
  logic [4:0]       wa_q,   wa_d;
  logic [31:0]      alu_q,  alu_d;
  logic [31:0]      dmrd_q, dmrd_d;
  logic [2:0]       lt_q,   lt_d;
  logic [1:0]       sel_q,  sel_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  logic             advance;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_data;

  // The W registers advance on a flush or on a fresh load. They do not
  // advance while stalled.
  assign advance = flush | ~stall;

  // Next state. A $0 destination never reaches W as a write.
  always_comb begin
    pc_d   = pc_q;
    we_d   = we_q;
    wa_d   = wa_q;
    alu_d  = alu_q;
    dmrd_d = dmrd_q;
    lt_d   = lt_q;
    sel_d  = sel_q;
    cnt_d  = cnt_q;
    if (flush) begin
      pc_d   = PC_RESET;
      we_d   = 1'b0;
      wa_d   = 5'd0;
      alu_d  = 32'd0;
      dmrd_d = 32'd0;
      lt_d   = 3'd0;
      sel_d  = 2'd0;
    end else if (!stall) begin
      pc_d   = M_PC;
      we_d   = M_we & (M_WA != 5'd0);
      wa_d   = M_WA;
      alu_d  = M_ALUOut;
      dmrd_d = M_DMRD;
      lt_d   = M_LdType;
      sel_d  = M_WDSel;
    end
    // The counted instruction is the one leaving W.
    if (advance && we_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // W register bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q   <= PC_RESET;
      we_q   <= 1'b0;
      wa_q   <= 5'd0;
      alu_q  <= 32'd0;
      dmrd_q <= 32'd0;
      lt_q   <= 3'd0;
      sel_q  <= 2'd0;
      cnt_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      we_q   <= we_d;
      wa_q   <= wa_d;
      alu_q  <= alu_d;
      dmrd_q <= dmrd_d;
      lt_q   <= lt_d;
      sel_q  <= sel_d;
      cnt_q  <= cnt_d;
    end
  end

  // Load extraction. Halfword selection ignores offset bit 0.
  always_comb begin
    ld_byte = 8'd0;
    case (alu_q[1:0])
      2'd0:    ld_byte = dmrd_q[7:0];
      2'd1:    ld_byte = dmrd_q[15:8];
      2'd2:    ld_byte = dmrd_q[23:16];
      default: ld_byte = dmrd_q[31:24];
    endcase
    ld_half = alu_q[1] ? dmrd_q[31:16] : dmrd_q[15:0];
    case (lt_q)
      LD_LBU:  ld_data = {24'd0, ld_byte};
      LD_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LD_LHU:  ld_data = {16'd0, ld_half};
      LD_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      default: ld_data = dmrd_q;
    endcase
  end

  // Write-back source select. PC+8 wraps modulo 2^32.
  always_comb begin
    case (sel_q)
      SEL_LOAD: W_WD = ld_data;
      SEL_PC8:  W_WD = pc_q + 32'd8;
      default:  W_WD = alu_q;
    endcase
  end

  assign W_PC      = pc_q;
  assign W_we      = we_q;
  assign W_WA      = wa_q;
  assign W_retired = cnt_q;

endmodule
